// File: rtl/ls597_defs_pkg.sv
// Shared state encodings and counter widths
// for the sn74ls597 scan controller.
package ls597_defs;

  localparam int PH_W = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LATCH = 3'd1,
    S_RLOW  = 3'd2,
    S_LOAD  = 3'd3,
    S_LREL  = 3'd4,
    S_SHI   = 3'd5,
    S_SLO   = 3'd6,
    S_DONE  = 3'd7
  } state_t;

  function automatic int bit_w(input int ndev);
    return $clog2(8 * ndev + 1);
  endfunction

endpackage

// File: rtl/ls597_scan_ctrl_if.sv
// Bus between the scan controller, its
// consumer and the cascaded '597 chain.
interface ls597_scan_ctrl_if #(
  parameter int NDEV = 2
);
  logic                start;
  logic                ack;
  logic                qh;
  logic                rck;
  logic                cload;
  logic                sck;
  logic                sclr;
  logic [8*NDEV-1:0]   data;
  logic                valid;
  logic                busy;

  modport master (
    input  start, ack, qh,
    output rck, cload, sck, sclr,
    output data, valid, busy
  );

  modport slave (
    output start, ack, qh,
    input  rck, cload, sck, sclr,
    input  data, valid, busy
  );
endinterface

// File: rtl/ls597_phase_timer.sv
// Loadable down-counter; tc marks the
// last cycle of a control phase.
module ls597_phase_timer
  import ls597_defs::*;
#(
  parameter int W = PH_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] val,
  output logic         tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (load)
      cnt <= val;
    else if (cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/ls597_scan_ctrl.sv
// Scan controller for a chain of NDEV
// sn74ls597 input shift registers.
module ls597_scan_ctrl
  import ls597_defs::*;
#(
  parameter int NDEV = 2,
  parameter int DIV  = 2
) (
  input logic clk,
  input logic rst,
  ls597_scan_ctrl_if.master bus
);

  localparam int N  = 8 * NDEV;
  localparam int BW = bit_w(NDEV);
  localparam logic [PH_W-1:0] PH_LD =
    PH_W'(DIV - 1);
  localparam logic [BW-1:0] NLAST =
    BW'(N - 1);

  state_t        state, state_n;
  logic [BW-1:0] bits;
  logic [N-1:0]  sh;
  logic [N-1:0]  sh_n;
  logic          tc;
  logic          load;
  logic          smp;

  ls597_phase_timer #(.W(PH_W)) u_tmr (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .val  (PH_LD),
    .tc   (tc)
  );

  assign sh_n = {sh[N-2:0], bus.qh};

  always_ff @(posedge clk) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    smp     = 1'b0;
    unique case (state)
      S_IDLE:
        if (bus.start) begin
          state_n = S_LATCH;
          load    = 1'b1;
        end
      S_LATCH:
        if (tc) begin
          state_n = S_RLOW;
          load    = 1'b1;
        end
      S_RLOW:
        if (tc) begin
          state_n = S_LOAD;
          load    = 1'b1;
        end
      S_LOAD:
        if (tc) begin
          state_n = S_LREL;
          load    = 1'b1;
        end
      S_LREL, S_SLO:
        if (tc) begin
          smp     = 1'b1;
          load    = 1'b1;
          state_n = (bits == NLAST) ?
                    S_DONE : S_SHI;
        end
      S_SHI:
        if (tc) begin
          state_n = S_SLO;
          load    = 1'b1;
        end
      S_DONE:
        if (bus.ack)
          state_n = S_IDLE;
      default:
        state_n = S_IDLE;
    endcase
  end

  // data only moves on the final sample
  always_ff @(posedge clk) begin
    if (rst) begin
      bits     <= '0;
      sh       <= '0;
      bus.data <= '0;
    end else begin
      if (state == S_IDLE && bus.start)
        bits <= '0;
      if (smp) begin
        sh   <= sh_n;
        bits <= bits + 1'b1;
      end
      if (smp && state_n == S_DONE)
        bus.data <= sh_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rck   <= 1'b0;
      bus.cload <= 1'b1;
      bus.sck   <= 1'b0;
      bus.sclr  <= 1'b0;
      bus.valid <= 1'b0;
      bus.busy  <= 1'b0;
    end else begin
      bus.rck   <= (state_n == S_LATCH);
      bus.cload <= (state_n != S_LOAD);
      bus.sck   <= (state_n == S_SHI);
      bus.sclr  <= 1'b1;
      bus.valid <= (state_n == S_DONE);
      bus.busy  <= (state_n != S_IDLE) &&
                   (state_n != S_DONE);
    end
  end

endmodule

// File: tb/tb_ls597_scan_ctrl.sv
// Scoreboard bench: two controllers, each
// driving a pair of behavioural '597s.
module tb_ls597_scan_ctrl;
  import ls597_defs::*;

  typedef struct {
    logic [15:0] d;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   nchk = 0;
  int   nerr = 0;
  int   viol = 0;
  int   sca = 0, scb = 0, stra = 0;
  exp_t qa[$], qb[$];
  logic vpa = 1'b0, vpb = 1'b0;

  logic [7:0] ina0, ina1, sta0, sta1;
  logic [7:0] sra0, sra1;
  logic [7:0] inb0, inb1, stb0, stb1;
  logic [7:0] srb0, srb1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ls597_scan_ctrl_if #(.NDEV(1)) ba ();
  ls597_scan_ctrl_if #(.NDEV(2)) bb ();

  ls597_scan_ctrl #(
    .NDEV(1), .DIV(2)
  ) ua (
    .clk (clk),
    .rst (rst),
    .bus (ba)
  );

  ls597_scan_ctrl #(
    .NDEV(2), .DIV(1)
  ) ub (
    .clk (clk),
    .rst (rst),
    .bus (bb)
  );

  // device 1 shifts into device 0
  always @(posedge ba.rck) begin
    sta0 <= ina0;
    sta1 <= ina1;
  end
  always @(posedge ba.sck or
           negedge ba.sclr or
           negedge ba.cload)
    if (!ba.sclr) begin
      sra0 <= '0;
      sra1 <= '0;
    end else if (!ba.cload) begin
      sra0 <= sta0;
      sra1 <= sta1;
    end else begin
      sra0 <= {sra0[6:0], sra1[7]};
      sra1 <= {sra1[6:0], 1'b0};
    end
  assign ba.qh = sra0[7];

  always @(posedge bb.rck) begin
    stb0 <= inb0;
    stb1 <= inb1;
  end
  always @(posedge bb.sck or
           negedge bb.sclr or
           negedge bb.cload)
    if (!bb.sclr) begin
      srb0 <= '0;
      srb1 <= '0;
    end else if (!bb.cload) begin
      srb0 <= stb0;
      srb1 <= stb1;
    end else begin
      srb0 <= {srb0[6:0], srb1[7]};
      srb1 <= {srb1[6:0], 1'b0};
    end
  assign bb.qh = srb0[7];

  always @(posedge ba.sck) sca++;
  always @(posedge bb.sck) scb++;
  always @(posedge ba.rck or
           negedge ba.cload or
           posedge ba.sck) stra++;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && ba.valid && !vpa) begin
      if (qa.size() == 0)
        check("a_unexpected", ba.valid, 0);
      else begin
        e = qa.pop_front();
        check("a_data", 32'(ba.data), 32'(e.d));
        check("a_latency", cyc, e.due);
      end
    end
    if (!rst && bb.valid && !vpb) begin
      if (qb.size() == 0)
        check("b_unexpected", bb.valid, 0);
      else begin
        e = qb.pop_front();
        check("b_data", 32'(bb.data), 32'(e.d));
        check("b_latency", cyc, e.due);
      end
    end
    vpa = ba.valid;
    vpb = bb.valid;
    if (!rst) begin
      if ((ba.rck && !ba.cload) ||
          (ba.rck && ba.sck) ||
          (!ba.cload && ba.sck) ||
          (ba.busy && ba.valid))
        viol++;
      if ((bb.rck && !bb.cload) ||
          (bb.rck && bb.sck) ||
          (!bb.cload && bb.sck) ||
          (bb.busy && bb.valid))
        viol++;
    end
  end

  task automatic wait_a();
    int n = 0;
    while (ba.valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200)
      check("a_timeout", ba.valid, 1);
  endtask

  task automatic wait_b();
    int n = 0;
    while (bb.valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200)
      check("b_timeout", bb.valid, 1);
  endtask

  task automatic scan_a(
    input logic [7:0] d0,
    input logic [7:0] d1
  );
    int s0;
    ina0 = d0;
    ina1 = d1;
    s0   = sca;
    qa.push_back('{d: 16'(d0), due: cyc + 37});
    ba.start = 1'b1;
    @(negedge clk);
    ba.start = 1'b0;
    wait_a();
    check("a_sck", sca - s0, 7);
  endtask

  task automatic scan_b(
    input logic [7:0] d0,
    input logic [7:0] d1
  );
    int s0;
    inb0 = d0;
    inb1 = d1;
    s0   = scb;
    qb.push_back('{d: {d0, d1}, due: cyc + 35});
    bb.start = 1'b1;
    @(negedge clk);
    bb.start = 1'b0;
    wait_b();
    check("b_sck", scb - s0, 15);
  endtask

  task automatic ack_a();
    ba.ack = 1'b1;
    @(negedge clk);
    ba.ack = 1'b0;
    check("a_ack_valid", ba.valid, 0);
    check("a_ack_busy", ba.busy, 0);
  endtask

  task automatic ack_b();
    bb.ack = 1'b1;
    @(negedge clk);
    bb.ack = 1'b0;
    check("b_ack_valid", bb.valid, 0);
    check("b_ack_busy", bb.busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t, s0, n;
    rst = 1'b1;
    ba.start = 1'b0;
    ba.ack   = 1'b0;
    bb.start = 1'b0;
    bb.ack   = 1'b0;
    ina0 = '0; ina1 = '0;
    inb0 = '0; inb1 = '0;
    repeat (3) @(negedge clk);
    check("a_rst_strobes",
      {ba.rck, ba.cload, ba.sck,
       ba.sclr, ba.valid, ba.busy},
      6'b010000);
    check("a_rst_data", ba.data, 0);
    check("b_rst_strobes",
      {bb.rck, bb.cload, bb.sck,
       bb.sclr, bb.valid, bb.busy},
      6'b010000);
    check("b_rst_data", bb.data, 0);
    rst = 1'b0;
    @(negedge clk);
    check("a_sclr_rel", ba.sclr, 1);
    check("b_sclr_rel", bb.sclr, 1);

    scan_a(8'hA5, 8'h5A);

    s0 = stra;
    for (int i = 0; i < 20; i++) begin
      ba.start = i[0];
      ina0 = 8'($urandom);
      ina1 = 8'($urandom);
      @(negedge clk);
      check("a_hold_valid", ba.valid, 1);
      check("a_hold_data", ba.data, 8'hA5);
    end
    ba.start = 1'b0;
    check("a_hold_strobes", stra - s0, 0);
    ack_a();

    ina0 = 8'h96;
    t  = cyc;
    s0 = sca;
    qa.push_back('{d: 16'h96, due: t + 37});
    qa.push_back('{d: 16'h96, due: t + 75});
    ba.start = 1'b1;
    ba.ack   = 1'b1;
    while (cyc < t + 75) begin
      @(negedge clk);
      if (cyc == t + 38)
        check("a_gap_idle",
              ba.busy | ba.valid, 0);
      if (cyc == t + 39)
        check("a_gap_latch", ba.rck, 1);
    end
    ba.start = 1'b0;
    @(negedge clk);
    ba.ack = 1'b0;
    check("a_b2b_idle",
          ba.valid | ba.busy, 0);
    check("a_b2b_sck", sca - s0, 14);

    scan_b(8'h3C, 8'h81);
    ack_b();

    inb0 = 8'($urandom);
    inb1 = 8'($urandom);
    bb.start = 1'b1;
    @(negedge clk);
    bb.start = 1'b0;
    n = 0;
    while (bb.sck !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("b_reach_shi", bb.sck, 1);
    rst = 1'b1;
    @(negedge clk);
    check("b_rst_sclr", bb.sclr, 0);
    check("b_rst_sck", bb.sck, 0);
    check("b_rst_busy", bb.busy, 0);
    check("b_rst_data", bb.data, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("b_rel_sclr", bb.sclr, 1);

    scan_b(8'h5E, 8'hC7);
    ack_b();

    check("a_queue", qa.size(), 0);
    check("b_queue", qb.size(), 0);
    check("mutex", viol, 0);
    $display("Simulation finished: %0d checks, %0d errors",
             nchk, nerr);
    $finish;
  end

endmodule
